// File: rtl/load_store_unit.sv
// CPU-side load/store initiator for a word-addressed, single-cycle data RAM.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module load_store_unit #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_error,
  output logic [ADDR_W-1:0] data_address,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_writedata,
  input  logic [31:0]       data_readdata
);

  localparam int unsigned BA_W = ADDR_W + 2;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err_c;
  logic [7:0]        byte_sel_c;
  logic [15:0]       half_sel_c;
  logic [31:0]       load_ext_c;
  logic [31:0]       merge_c;

  // Alignment, size and range checks on the incoming request
  always_comb begin
    req_err_c = 1'b0;
    if (req_size == 2'b11)                          req_err_c = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])       req_err_c = 1'b1;
    if ((req_size == SZ_WORD) && (|req_addr[1:0]))  req_err_c = 1'b1;
    if ((req_addr >> BA_W) != 32'd0)                req_err_c = 1'b1;
  end

  // Lane extraction and sign/zero extension of the RAM read word
  always_comb begin
    byte_sel_c = data_readdata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel_c = data_readdata[7:0];
      2'd1:    byte_sel_c = data_readdata[15:8];
      2'd2:    byte_sel_c = data_readdata[23:16];
      default: byte_sel_c = data_readdata[31:24];
    endcase
    half_sel_c = addr_q[1] ? data_readdata[31:16] : data_readdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext_c = {{24{~uns_q & byte_sel_c[7]}}, byte_sel_c};
      SZ_HALF: load_ext_c = {{16{~uns_q & half_sel_c[15]}}, half_sel_c};
      default: load_ext_c = data_readdata;
    endcase
  end

  // Sub-word store merge: replace only the addressed lane(s)
  always_comb begin
    merge_c = data_readdata;
    if (size_q == SZ_HALF) begin
      if (addr_q[1]) merge_c[31:16] = wdata_q[15:0];
      else           merge_c[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[BA_W-1:0];
          wdata_d = req_wdata;
          err_d   = req_err_c;
          if (req_err_c)              state_d = S_DONE;
          else if (!req_write)        state_d = S_LOAD;
          else if (req_size == SZ_WORD) state_d = S_WRITE;
          else                        state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_ext_c;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        merge_d = merge_c;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state; write strobe is gated by reset
  assign req_ready      = (state_q == S_IDLE);
  assign done           = (state_q == S_DONE);
  assign addr_error     = (state_q == S_DONE) & err_q;
  assign data_read      = (state_q == S_LOAD) | (state_q == S_RMW_RD);
  assign data_write     = (state_q == S_WRITE) & ~reset;
  assign data_writedata = (state_q != S_WRITE) ? 32'd0 :
                          (size_q == SZ_WORD)  ? wdata_q : merge_q;
  assign data_address   = addr_q[BA_W-1:2];
  assign rdata          = rdata_q;

  logic unused_c;
  assign unused_c = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard queue, RAM model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic [31:0] rdata;
  logic        addr_error;
  logic [3:0]  data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_waddr;
  } rec_t;

  rec_t tbl[$];
  rec_t exp_q[$];

  load_store_unit #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .addr_error(addr_error), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  // Single-cycle RAM: combinational read, synchronous write
  assign data_readdata = mem[data_address];
  always @(posedge clk) if (data_write) mem[data_address] <= data_writedata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    if (data_read && data_write) begin
      errors++;
      $display("FAIL strobe_overlap: data_read=%b data_write=%b at %0t", data_read, data_write, $time);
    end
  end

  function automatic rec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] erd, input logic eerr, input int lat,
                              input logic erd_s, input logic ewr_s,
                              input logic [31:0] ewd, input logic [3:0] ewa);
    rec_t r;
    r.wr = wr; r.sz = sz; r.uns = uns; r.addr = addr; r.wdata = wdata;
    r.exp_rdata = erd; r.exp_err = eerr; r.exp_lat = lat;
    r.exp_rd = erd_s; r.exp_wr = ewr_s; r.exp_wdata = ewd; r.exp_waddr = ewa;
    return r;
  endfunction

  // Drive one request, track strobes until done, compare against scoreboard head
  task automatic run_req(input rec_t r, input bit hold, input string tag);
    int guard = 0;
    int cyc = 0;
    bit got = 0, saw_rd = 0, saw_wr = 0;
    logic [31:0] wd = 32'd0;
    logic [3:0]  wa = 4'd0;
    rec_t e;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = r.wr; req_size = r.sz; req_unsigned = r.uns;
    req_addr = r.addr; req_wdata = r.wdata;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (data_read) saw_rd = 1;
      if (data_write) begin
        saw_wr = 1; wd = data_writedata; wa = data_address;
      end
      if (done) got = 1;
    end
    e = exp_q.pop_front();
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(e.exp_lat));
    chk({tag, "_rdata"}, rdata, e.exp_rdata);
    chk({tag, "_addr_error"}, {31'd0, addr_error}, {31'd0, e.exp_err});
    chk({tag, "_saw_read"}, {31'd0, saw_rd}, {31'd0, e.exp_rd});
    chk({tag, "_saw_write"}, {31'd0, saw_wr}, {31'd0, e.exp_wr});
    if (e.exp_wr) begin
      chk({tag, "_wdata"}, wd, e.exp_wdata);
      chk({tag, "_waddr"}, {28'd0, wa}, {28'd0, e.exp_waddr});
    end
  endtask

  initial begin
    rec_t r1, r2;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    //             wr sz     u  addr   wdata         exp_rdata     err lat rd wr exp_wdata     waddr
    tbl.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h00000000, 0, 2, 0, 1, 32'hDEADBEEF, 4'd2));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0B, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h09, 32'h0,        32'h000000BE, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h0A, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h08, 32'h0,        32'h0000BEEF, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h09, 32'h00000012, 32'hDEADBEEF, 0, 3, 1, 1, 32'hDEAD12EF, 4'd2));
    tbl.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0,        32'hDEAD12EF, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'hDEAD12EF, 0, 2, 0, 1, 32'hDEADBEEF, 4'd2));
    tbl.push_back(mk(1, 2'b01, 0, 32'h0A, 32'h00005678, 32'hDEAD12EF, 0, 3, 1, 1, 32'h5678BEEF, 4'd2));
    tbl.push_back(mk(0, 2'b10, 1, 32'h08, 32'h0,        32'h5678BEEF, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h08, 32'h0,        32'hFFFFFFEF, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h0B, 32'h0,        32'h00000056, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h08, 32'h0,        32'hFFFFBEEF, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h06, 32'h0,        32'hFFFFBEEF, 1, 1, 0, 0, 32'h0, 4'd0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h03, 32'h0000AAAA, 32'hFFFFBEEF, 1, 1, 0, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b11, 0, 32'h00, 32'h0,        32'hFFFFBEEF, 1, 1, 0, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0,        32'hFFFFBEEF, 1, 1, 0, 0, 32'h0, 4'd0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h3F, 32'h000000A5, 32'hFFFFBEEF, 0, 3, 1, 1, 32'hA5000000, 4'd15));
    tbl.push_back(mk(0, 2'b00, 0, 32'h3F, 32'h0,        32'hFFFFFFA5, 0, 2, 1, 0, 32'h0, 4'd0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h3E, 32'h0,        32'h0000A500, 0, 2, 1, 0, 32'h0, 4'd0));

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr_error", {31'd0, addr_error}, 32'd0);
    chk("rst_strobes", {30'd0, data_read, data_write}, 32'd0);
    chk("rst_address", {28'd0, data_address}, 32'd0);
    chk("rst_writedata", data_writedata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run_req(tbl[i], 1'b0, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset while an SB sits in its read phase: no write, no done, RAM intact
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h09; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_rmw_read", {31'd0, data_read}, 32'd1);
    reset = 1'b1;
    #1 chk("mid_rst_write_forced_low", {31'd0, data_write}, 32'd0);
    @(negedge clk);
    chk("mid_rst_write_low", {31'd0, data_write}, 32'd0);
    chk("mid_rst_no_done", {31'd0, done}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rdata_cleared", rdata, 32'd0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    run_req(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h5678BEEF, 0, 2, 1, 0, 32'h0, 4'd0), 1'b0, "post_rst_lw");
    @(negedge clk);

    // Two word loads with req_valid held high across DONE
    r1 = mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h5678BEEF, 0, 2, 1, 0, 32'h0, 4'd0);
    r2 = mk(0, 2'b10, 0, 32'h3C, 32'h0, 32'hA5000000, 0, 2, 1, 0, 32'h0, 4'd0);
    run_req(r1, 1'b1, "b2b_first");
    chk("b2b_not_ready_in_done", {31'd0, req_ready}, 32'd0);
    req_addr = 32'h3C;
    @(negedge clk);
    chk("b2b_ready_next_idle", {31'd0, req_ready}, 32'd1);
    run_req(r2, 1'b0, "b2b_second");
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
